// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ex writes win, long-latency results queue in a FIFO.
// Optional WB_BYPASS_EN lets a lu result skip the empty FIFO into the output stage.
module wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wr_en_i,
    input  logic [4:0]  ex_wr_addr_i,
    input  logic [31:0] ex_wr_data_i,
    input  logic        lu_valid_i,
    output logic        lu_ready_o,
    input  logic [4:0]  lu_wr_addr_i,
    input  logic [31:0] lu_wr_data_i,
    output logic        wr_en_o,
    output logic [4:0]  wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        ex_stall_o,
    output logic        busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    age_q, age_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [4:0]    addr_mem_q [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];

    logic ex_eff, empty, push, pop, bypass;

    assign lu_ready_o = (count_q != CW'(DEPTH));
    assign busy_o     = !empty;
    assign ex_stall_o = (age_q == 8'(STARVE_MAX));
    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = wr_addr_q;
    assign wr_data_o  = wr_data_q;

    always_comb begin
        ex_eff = ex_wr_en_i && (ex_wr_addr_i != 5'd0);
        empty  = (count_q == '0);
        bypass = 1'b0;
`ifdef WB_BYPASS_EN
        bypass = empty && !ex_eff && lu_valid_i && (lu_wr_addr_i != 5'd0);
`else
        bypass = 1'b0;
`endif
        // x0 results are handshaken but never stored
        push = lu_valid_i && lu_ready_o && (lu_wr_addr_i != 5'd0) && !bypass;
        pop  = !ex_eff && !empty;

        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (ex_eff) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ex_wr_addr_i;
            wr_data_d = ex_wr_data_i;
        end else if (pop) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_mem_q[rptr_q];
            wr_data_d = data_mem_q[rptr_q];
        end else if (bypass) begin
            wr_en_d   = 1'b1;
            wr_addr_d = lu_wr_addr_i;
            wr_data_d = lu_wr_data_i;
        end

        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);

        age_d = age_q;
        if (empty || pop) begin
            age_d = 8'd0;
        end else if (age_q != 8'(STARVE_MAX)) begin
            age_d = age_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            age_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            age_q     <= age_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Storage needs no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wptr_q] <= lu_wr_addr_i;
            data_mem_q[wptr_q] <= lu_wr_data_i;
        end
    end

endmodule
